// File: rtl/iterative_alu.sv
// Handshaked WIDTH-bit ALU with single-cycle logic/shift/compare ops and iterative MUL/MULHU.
// Define ITERATIVE_ALU_DIV_EN to build the iterative DIV/DIVU/REM/REMU datapath.
module iterative_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_err
);
  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpAnd   = 4'b0010;
  localparam logic [3:0] OpOr    = 4'b0011;
  localparam logic [3:0] OpXor   = 4'b0100;
  localparam logic [3:0] OpSll   = 4'b0101;
  localparam logic [3:0] OpSrl   = 4'b0110;
  localparam logic [3:0] OpSlt   = 4'b0111;
  localparam logic [3:0] OpSra   = 4'b1000;
  localparam logic [3:0] OpSltu  = 4'b1001;
  localparam logic [3:0] OpMul   = 4'b1010;
  localparam logic [3:0] OpMulhu = 4'b1011;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opd_q;
  logic [SW-1:0]      cnt_q;
  logic               hi_sel_q;

  logic [WIDTH-1:0]   imm_res;
  logic               imm_err;
  logic               start_iter;
  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] step_next;
  logic [WIDTH-1:0]   fin_res;

  assign shamt     = in_b[SW-1:0];
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

`ifdef ITERATIVE_ALU_DIV_EN
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  logic               is_div_q;
  logic               q_neg_q;
  logic               r_neg_q;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Signed ops have in_op[0] == 0; unsigned variants never see a negative operand.
  assign a_neg = ~in_op[0] & in_a[WIDTH-1];
  assign b_neg = ~in_op[0] & in_b[WIDTH-1];
  assign a_mag = a_neg ? -in_a : in_a;
  assign b_mag = b_neg ? -in_b : in_b;

  // Restoring step: acc_q holds {partial remainder, dividend bits / quotient bits}.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opd_q});
  assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opd_q}) : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
  assign quo_fix   = q_neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
  assign rem_fix   = r_neg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    imm_res    = '0;
    imm_err    = 1'b0;
    start_iter = 1'b0;
    case (in_op)
      OpAdd:   imm_res = in_a + in_b;
      OpSub:   imm_res = in_a - in_b;
      OpAnd:   imm_res = in_a & in_b;
      OpOr:    imm_res = in_a | in_b;
      OpXor:   imm_res = in_a ^ in_b;
      OpSll:   imm_res = in_a << shamt;
      OpSrl:   imm_res = in_a >> shamt;
      OpSlt:   imm_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OpSra:   imm_res = $signed(in_a) >>> shamt;
      OpSltu:  imm_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OpMul, OpMulhu: start_iter = 1'b1;
`ifdef ITERATIVE_ALU_DIV_EN
      default: begin
        // in_op[1] selects remainder; special cases finish without iterating.
        if (in_b == '0) begin
          imm_res = in_op[1] ? in_a : '1;
        end else if (!in_op[0] && in_a == MinVal && in_b == '1) begin
          imm_res = in_op[1] ? '0 : in_a;
        end else begin
          start_iter = 1'b1;
        end
      end
`else
      default: begin
        imm_res = '0;
        imm_err = 1'b1;
      end
`endif
    endcase
  end

  // Shift-add: acc_q = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  always_comb begin
    step_next = mul_next;
    fin_res   = hi_sel_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
`ifdef ITERATIVE_ALU_DIV_EN
    if (is_div_q) begin
      step_next = div_next;
      fin_res   = hi_sel_q ? rem_fix : quo_fix;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      opd_q      <= '0;
      cnt_q      <= '0;
      hi_sel_q   <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_err    <= 1'b0;
`ifdef ITERATIVE_ALU_DIV_EN
      is_div_q   <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            cnt_q    <= '0;
            hi_sel_q <= in_op[2] ? in_op[1] : in_op[0];
            if (start_iter) begin
              state_q <= StBusy;
              opd_q   <= in_a;
              acc_q   <= {{WIDTH{1'b0}}, in_b};
`ifdef ITERATIVE_ALU_DIV_EN
              is_div_q <= in_op[2];
              q_neg_q  <= a_neg ^ b_neg;
              r_neg_q  <= a_neg;
              if (in_op[2]) begin
                opd_q <= b_mag;
                acc_q <= {{WIDTH{1'b0}}, a_mag};
              end
`endif
            end else begin
              state_q    <= StDone;
              out_result <= imm_res;
              out_zero   <= (imm_res == '0);
              out_err    <= imm_err;
            end
          end
        end
        StBusy: begin
          acc_q <= step_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SW'(WIDTH - 1)) begin
            state_q    <= StDone;
            out_result <= fin_res;
            out_zero   <= (fin_res == '0);
            out_err    <= 1'b0;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu (WIDTH=32); expectations follow ITERATIVE_ALU_DIV_EN.
module tb_iterative_alu;
  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [3:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_zero;
  logic          out_err;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  iterative_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] prod;
    prod  = {32'b0, a} * {32'b0, b};
    e.res = '0;
    e.err = 1'b0;
    e.lat = 1;
    case (op)
      4'd0:  e.res = a + b;
      4'd1:  e.res = a - b;
      4'd2:  e.res = a & b;
      4'd3:  e.res = a | b;
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = a << b[4:0];
      4'd6:  e.res = a >> b[4:0];
      4'd7:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  e.res = $signed(a) >>> b[4:0];
      4'd9:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd10: begin e.res = prod[31:0];  e.lat = 33; end
      4'd11: begin e.res = prod[63:32]; e.lat = 33; end
      default: begin
`ifdef ITERATIVE_ALU_DIV_EN
        if (b == 0) begin
          e.res = (op == 4'd12 || op == 4'd13) ? 32'hFFFF_FFFF : a;
        end else if ((op == 4'd12 || op == 4'd14) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.res = (op == 4'd12) ? a : 32'd0;
        end else begin
          e.lat = 33;
          case (op)
            4'd12:   e.res = $signed(a) / $signed(b);
            4'd13:   e.res = a / b;
            4'd14:   e.res = $signed(a) % $signed(b);
            default: e.res = a % b;
          endcase
        end
`else
        e.res = '0;
        e.err = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge after the handshake.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall);
    exp_t         e;
    int           lat;
    int           guard;
    logic         rdy_seen;
    logic         stable;
    logic [W-1:0] held;
    sb.push_back(model(op, a, b));
    out_ready = (stall == 0);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    check("accept_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      rdy_seen |= in_ready;
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check($sformatf("latency op%0d", op), 64'(lat), 64'(e.lat));
    check("busy_in_ready", rdy_seen, 1'b0);
    if (stall > 0) begin
      held = out_result;
      stable = 1'b1;
      in_op = 4'd0; in_a = 32'd5; in_b = 32'd6; in_valid = 1'b1;
      repeat (stall) begin
        @(negedge clk);
        stable &= (out_result == held) && out_valid && !in_ready;
      end
      check("stall_hold", stable, 1'b1);
      out_ready = 1'b1;
    end
    check($sformatf("result op%0d a=%0h b=%0h", op, a, b), out_result, e.res);
    check("zero_flag", out_zero, (e.res == '0));
    check("err_flag", out_err, e.err);
    @(negedge clk);
    check("valid_drop", out_valid, 1'b0);
    if (stall > 0) begin
      check("ready_after_stall", in_ready, 1'b1);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic spurious;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", out_result, '0);
    check("rst_zero", out_zero, 1'b0);
    check("rst_err", out_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd0,  32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd8,  32'h8000_0000, 32'd4, 0);
    run_op(4'd7,  32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd9,  32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd1,  32'd3,         32'd5, 0);
    run_op(4'd5,  32'h0000_00F1, 32'h0000_0124, 0);
    run_op(4'd6,  32'h8000_00F0, 32'd31, 0);
    run_op(4'd4,  32'hA5A5_A5A5, 32'hFFFF_0000, 0);
    run_op(4'd10, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(4'd11, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(4'd12, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(4'd14, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(4'd13, 32'd7,         32'd0, 0);
    run_op(4'd15, 32'd7,         32'd0, 0);
    run_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(4'd12, 32'd10,        32'd2, 0);
    run_op(4'd14, 32'd7,         32'hFFFF_FFFE, 0);
    run_op(4'd13, 32'hFFFF_FFF0, 32'd7, 0);
    run_op(4'd3,  32'h1234_0000, 32'h0000_5678, 5);
    run_op(4'd10, 32'd12345,     32'd678, 5);
    for (int i = 0; i < 16; i++) begin
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom, 0);
    end

    // Reset during the tenth MUL iteration must discard the operation.
    run_op(4'd0, 32'd3, 32'd4, 0);
    in_op = 4'd10; in_a = 32'd7; in_b = 32'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_result", out_result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    repeat (40) begin
      @(negedge clk);
      spurious |= out_valid;
    end
    check("no_spurious_result", spurious, 1'b0);
    run_op(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
